// File: rtl/system_button_pio_pkg.sv
// Shared register addresses and sizing helpers for the button/switch input PIO.
package system_button_pio_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_RISE = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_FALL = 3'd4;
    localparam logic [2:0] ADDR_RAW  = 3'd5;

    // Width needed to hold 0..cycles, never less than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/system_button_pio_debounce.sv
// One input channel: 2-flop synchroniser, stability counter and debounced flop.
// update pulses for one cycle on the edge where debounced takes the new level.
import system_button_pio_pkg::*;

module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    output logic debounced,
    output logic update,
    output logic raw
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] count;
    logic          differs;

    assign differs = (sync2 != debounced);
    assign update  = differs && (count == LAST_COUNT);
    assign raw     = sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= in_bit;
            sync2 <= sync1;
        end
    end

    // Any return to the debounced level restarts the stability window.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            debounced <= IDLE_LEVEL;
        end else if (!differs) begin
            count <= '0;
        end else if (update) begin
            count     <= '0;
            debounced <= sync2;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/system_button_pio.sv
// Avalon-MM input PIO for buttons/switches: per-channel debounce, selectable
// rising/falling edge capture, and a masked level interrupt.
import system_button_pio_pkg::*;

module system_button_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] update;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_event;
    logic [WIDTH-1:0] edge_clear;
    logic [WIDTH-1:0] wdata;
    logic             wr;
    logic             unused_wdata;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_ch
            button_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .IDLE_LEVEL      (IDLE_LEVEL)
            ) u_debounce (
                .clk       (clk),
                .reset     (reset),
                .in_bit    (in_port[i]),
                .debounced (debounced[i]),
                .update    (update[i]),
                .raw       (raw[i])
            );
        end
    endgenerate

    assign wr           = chipselect && !write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    // On update, raw already holds the level debounced is about to take.
    assign edge_event = update & ((raw & rise_en) | (~raw & fall_en));
    assign edge_clear = (wr && address == ADDR_EDGE) ? wdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_en  <= '0;
            fall_en  <= '0;
            irq_mask <= '0;
        end else if (wr) begin
            case (address)
                ADDR_RISE: rise_en  <= wdata;
                ADDR_MASK: irq_mask <= wdata;
                ADDR_FALL: fall_en  <= wdata;
                default:   ;
            endcase
        end
    end

    // A fresh edge outranks a clearing write to the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~edge_clear) | edge_event;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_DATA: readdata <= 32'(debounced);
                ADDR_RISE: readdata <= 32'(rise_en);
                ADDR_MASK: readdata <= 32'(irq_mask);
                ADDR_EDGE: readdata <= 32'(edge_capture);
                ADDR_FALL: readdata <= 32'(fall_en);
                ADDR_RAW:  readdata <= 32'(raw);
                default:   readdata <= '0;
            endcase
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule
